// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the branch resolve unit and its tracking slots.
package bru_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

    typedef struct packed {
        logic            valid;
        logic            is_branch;
        logic            pred;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
    } bru_slot_t;

    // Fall-through address; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch/EX/predictor-facing signals of the branch resolve unit, grouped as one bus.
interface branch_resolve_unit_if;
    import bru_pkg::*;

    logic            if_valid;
    logic            if_is_branch;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_target;
    logic            pred_taken;
    logic            stall;
    logic            ex_cond_true;

    logic            fetch_take_pred;
    logic            mispredicted;
    logic            update_en;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            flush;

    modport slave (
        input  if_valid, if_is_branch, if_pc, if_target, pred_taken, stall, ex_cond_true,
        output fetch_take_pred, mispredicted, update_en, redirect_valid, redirect_pc, flush
    );

    modport master (
        output if_valid, if_is_branch, if_pc, if_target, pred_taken, stall, ex_cond_true,
        input  fetch_take_pred, mispredicted, update_en, redirect_valid, redirect_pc, flush
    );

endinterface

// File: rtl/branch_resolve_unit_slot.sv
// One branch tracking register; flush beats stall, stall beats load.
module bru_slot
    import bru_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      flush_i,
    input  logic      stall_i,
    input  bru_slot_t load_i,
    output bru_slot_t slot_o
);

    bru_slot_t slot_q;
    bru_slot_t slot_d;

    always_comb begin
        slot_d = slot_q;
        if (flush_i) begin
            slot_d = '0;
        end else if (!stall_i) begin
            slot_d = load_i;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Tracks fetched branches IF->ID->EX and resolves predictions at EX.
// Optional statistics counters are enabled with `define BRU_STATS_EN.
module branch_resolve_unit
    import bru_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    branch_resolve_unit_if.slave  bus
`ifdef BRU_STATS_EN
    ,
    output logic [31:0]           stat_branches,
    output logic [31:0]           stat_mispredicts
`endif
);

    bru_slot_t       if_load;
    bru_slot_t       id_slot;
    bru_slot_t       ex_slot;
    logic            resolve;
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;

    assign if_load = '{valid:     bus.if_valid,
                       is_branch: bus.if_is_branch,
                       pred:      bus.pred_taken,
                       pc:        bus.if_pc,
                       target:    bus.if_target};

    bru_slot u_id_slot (
        .clk     (clk),
        .rst     (rst),
        .flush_i (mispredict),
        .stall_i (bus.stall),
        .load_i  (if_load),
        .slot_o  (id_slot)
    );

    bru_slot u_ex_slot (
        .clk     (clk),
        .rst     (rst),
        .flush_i (mispredict),
        .stall_i (bus.stall),
        .load_i  (id_slot),
        .slot_o  (ex_slot)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        resolve     = ex_slot.valid & ex_slot.is_branch & ~bus.stall;
        mispredict  = resolve & (bus.ex_cond_true != ex_slot.pred);
        redirect_pc = '0;
        if (mispredict) begin
            redirect_pc = bus.ex_cond_true ? ex_slot.target : next_seq_pc(ex_slot.pc);
        end
    end

    // Gated by reset so the output reads 0 while reset is held, whatever fetch presents.
    assign bus.fetch_take_pred = rst & bus.if_valid & bus.if_is_branch & bus.pred_taken & ~mispredict;
    assign bus.update_en       = resolve;
    assign bus.mispredicted    = mispredict;
    assign bus.redirect_valid  = mispredict;
    assign bus.flush           = mispredict;
    assign bus.redirect_pc     = redirect_pc;

`ifdef BRU_STATS_EN
    logic [31:0] stat_br_q, stat_br_d;
    logic [31:0] stat_mis_q, stat_mis_d;

    always_comb begin
        stat_br_d  = stat_br_q;
        stat_mis_d = stat_mis_q;
        if (resolve && stat_br_q != 32'hFFFF_FFFF) begin
            stat_br_d = stat_br_q + 32'd1;
        end
        if (mispredict && stat_mis_q != 32'hFFFF_FFFF) begin
            stat_mis_d = stat_mis_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else begin
            stat_br_q  <= stat_br_d;
            stat_mis_q <= stat_mis_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed, table-driven bench for branch_resolve_unit (default and BRU_STATS_EN builds).
module tb_branch_resolve_unit;
    import bru_pkg::*;

    typedef struct {
        logic        iv;
        logic        br;
        logic        pred;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        stall;
        logic        cond;
        logic        e_ftp;
        logic        e_upd;
        logic        e_mis;
        logic [31:0] e_rpc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    branch_resolve_unit_if bus ();

`ifdef BRU_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    branch_resolve_unit dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus)
`ifdef BRU_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    vec_t main_v[15];
    vec_t stall_v[8];

    function automatic vec_t mk(logic iv, logic br, logic pred, logic [31:0] pc, logic [31:0] tgt,
                                logic stall, logic cond, logic e_ftp, logic e_upd, logic e_mis,
                                logic [31:0] e_rpc);
        vec_t v;
        v.iv = iv; v.br = br; v.pred = pred; v.pc = pc; v.tgt = tgt;
        v.stall = stall; v.cond = cond;
        v.e_ftp = e_ftp; v.e_upd = e_upd; v.e_mis = e_mis; v.e_rpc = e_rpc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.if_valid     = v.iv;
        bus.if_is_branch = v.br;
        bus.pred_taken   = v.pred;
        bus.if_pc        = v.pc;
        bus.if_target    = v.tgt;
        bus.stall        = v.stall;
        bus.ex_cond_true = v.cond;
    endtask

    task automatic check_outs(input string tag, input logic ftp, input logic upd,
                              input logic mis, input logic [31:0] rpc);
        check({tag, ".fetch_take_pred"}, 32'(bus.fetch_take_pred), 32'(ftp));
        check({tag, ".update_en"},       32'(bus.update_en),       32'(upd));
        check({tag, ".mispredicted"},    32'(bus.mispredicted),    32'(mis));
        check({tag, ".redirect_valid"},  32'(bus.redirect_valid),  32'(mis));
        check({tag, ".flush"},           32'(bus.flush),           32'(mis));
        check({tag, ".redirect_pc"},     bus.redirect_pc,          rpc);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        check_outs(tag, v.e_ftp, v.e_upd, v.e_mis, v.e_rpc);
    endtask

    initial begin
        int   upd_pulses;
        vec_t idle;

        //                iv br pr pc            tgt           st cd  ftp upd mis rpc
        main_v[0]  = mk(1, 1, 0, 32'h100,      32'h180,      0, 0,  0, 0, 0, 32'h0);
        main_v[1]  = mk(1, 0, 1, 32'h104,      32'h0,        0, 0,  0, 0, 0, 32'h0);
        main_v[2]  = mk(1, 1, 0, 32'h200,      32'h240,      0, 0,  0, 1, 0, 32'h0);
        main_v[3]  = mk(1, 0, 0, 32'h204,      32'h0,        0, 1,  0, 0, 0, 32'h0);
        main_v[4]  = mk(1, 1, 1, 32'h300,      32'h380,      0, 1,  0, 1, 1, 32'h240);
        main_v[5]  = mk(1, 0, 1, 32'h240,      32'h0,        0, 1,  0, 0, 0, 32'h0);
        main_v[6]  = mk(1, 1, 1, 32'hFFFFFFFC, 32'h10,       0, 0,  1, 0, 0, 32'h0);
        main_v[7]  = mk(1, 0, 0, 32'h10,       32'h0,        0, 1,  0, 0, 0, 32'h0);
        main_v[8]  = mk(1, 0, 0, 32'h14,       32'h0,        0, 0,  0, 1, 1, 32'h0);
        main_v[9]  = mk(1, 1, 1, 32'h0,        32'h40,       0, 0,  1, 0, 0, 32'h0);
        main_v[10] = mk(0, 0, 0, 32'h0,        32'h0,        0, 0,  0, 0, 0, 32'h0);
        main_v[11] = mk(0, 1, 1, 32'h44,       32'h0,        0, 1,  0, 1, 0, 32'h0);
        main_v[12] = mk(1, 1, 0, 32'h40,       32'h80,       0, 0,  0, 0, 0, 32'h0);
        main_v[13] = mk(0, 0, 0, 32'h0,        32'h0,        0, 0,  0, 0, 0, 32'h0);
        main_v[14] = mk(0, 0, 0, 32'h0,        32'h0,        0, 0,  0, 1, 0, 32'h0);

        stall_v[0] = mk(1, 1, 0, 32'h500,      32'h600,      0, 0,  0, 0, 0, 32'h0);
        stall_v[1] = mk(1, 1, 1, 32'h504,      32'h700,      0, 0,  1, 0, 0, 32'h0);
        stall_v[2] = mk(1, 1, 1, 32'h508,      32'h800,      1, 0,  1, 0, 0, 32'h0);
        stall_v[3] = mk(1, 1, 1, 32'h508,      32'h800,      1, 0,  1, 0, 0, 32'h0);
        stall_v[4] = mk(1, 1, 1, 32'h508,      32'h800,      1, 0,  1, 0, 0, 32'h0);
        stall_v[5] = mk(1, 0, 0, 32'h508,      32'h0,        0, 0,  0, 1, 0, 32'h0);
        stall_v[6] = mk(1, 0, 0, 32'h50C,      32'h0,        0, 0,  0, 1, 1, 32'h508);
        stall_v[7] = mk(0, 0, 0, 32'h0,        32'h0,        0, 1,  0, 0, 0, 32'h0);

        idle = mk(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0);

        // Reset held with random inputs: every output must stay 0.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.if_valid     = 1'b1;
            bus.if_is_branch = 1'b1;
            bus.pred_taken   = 1'b1;
            bus.if_pc        = $urandom;
            bus.if_target    = $urandom;
            bus.stall        = 1'($urandom);
            bus.ex_cond_true = 1'($urandom);
            #1;
            check_outs($sformatf("reset%0d", i), 0, 0, 0, 32'h0);
        end
`ifdef BRU_STATS_EN
        check("reset.stat_branches", stat_branches, 32'h0);
        check("reset.stat_mispredicts", stat_mispredicts, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b1;
        drive(idle);

        for (int i = 0; i < 15; i++) begin
            run_vec($sformatf("main%0d", i), main_v[i]);
        end

`ifdef BRU_STATS_EN
        check("stats.branches", stat_branches, 32'd5);
        check("stats.mispredicts", stat_mispredicts, 32'd2);
        @(negedge clk);
        force dut.stat_br_q = 32'hFFFF_FFFF;
        #1;
        release dut.stat_br_q;
`endif

        // Branch held in EX under a 3-cycle stall: exactly one update on release.
        upd_pulses = 0;
        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("stall%0d", i), stall_v[i]);
            if (i >= 2 && i <= 5 && bus.update_en) upd_pulses++;
        end
        check("stall.update_pulses", 32'(upd_pulses), 32'd1);

`ifdef BRU_STATS_EN
        check("stats.branches_saturated", stat_branches, 32'hFFFF_FFFF);
        check("stats.mispredicts_after_stall", stat_mispredicts, 32'd3);
`endif

        // Reset asserted while a mispredict is being signalled.
        run_vec("mid0", mk(1, 1, 0, 32'h900, 32'h9A0, 0, 0, 0, 0, 0, 32'h0));
        run_vec("mid1", mk(1, 0, 0, 32'h904, 32'h0,   0, 0, 0, 0, 0, 32'h0));
        run_vec("mid2", mk(1, 1, 1, 32'h908, 32'hA00, 0, 1, 0, 1, 1, 32'h9A0));
        rst = 1'b0;
        #1;
        check_outs("mid_rst", 0, 0, 0, 32'h0);
`ifdef BRU_STATS_EN
        check("mid_rst.stat_branches", stat_branches, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b1;
        drive(mk(0, 0, 0, 32'h0, 32'h0, 0, 1, 0, 0, 0, 32'h0));
        #1;
        check_outs("post_rst0", 0, 0, 0, 32'h0);
        run_vec("post_rst1", mk(0, 0, 0, 32'h0, 32'h0, 0, 1, 0, 0, 0, 32'h0));
        run_vec("post_rst2", mk(0, 0, 0, 32'h0, 32'h0, 0, 1, 0, 0, 0, 32'h0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
